// File: rtl/video_pattern_sched.sv
// Test-pattern scheduler for the HDMI pixel-data generator.
// Auto-cycles or steps on a debounced key, changing pattern only on vsync rising edges.
//
// state       | meaning
// S_WAIT_SYNC | reset done, waiting for the first frame boundary; pattern held at 0
// S_RUN       | normal operation: auto expiry or pending key press advances on frame_tick
// S_FREEZE    | pattern and frame counter held; key presses discarded
module video_pattern_sched #(
   parameter int          NUM_PATTERNS       = 8,
   parameter int          FRAMES_PER_PATTERN = 60,
   parameter logic [19:0] DEBOUNCE_CYCLES    = 20'd1000000
) (
   input  logic       pixel_clk,
   input  logic       sys_rst,
   input  logic       vsync_in,
   input  logic       key_n,
   input  logic       auto_en,
   input  logic       freeze,
   output logic [2:0] pattern_sel,
   output logic       pattern_chg,
   output logic       locked
);

   localparam logic [1:0] S_WAIT_SYNC = 2'd0;
   localparam logic [1:0] S_RUN       = 2'd1;
   localparam logic [1:0] S_FREEZE    = 2'd2;

   localparam logic [2:0]  LAST_PAT   = 3'(NUM_PATTERNS - 1);
   localparam logic [7:0]  LAST_FRAME = 8'(FRAMES_PER_PATTERN - 1);
   localparam logic [19:0] DEB_LAST   = DEBOUNCE_CYCLES - 20'd1;

   logic        vsync_d;
   logic        frame_tick;
   logic        key_s1, key_s2;
   logic        deb_state, deb_d;
   logic [19:0] deb_cnt;
   logic        press;
   logic        pending;
   logic [7:0]  frame_cnt;
   logic [1:0]  state;
   logic        advance;

   assign frame_tick = vsync_in & ~vsync_d;
   assign press      = deb_d & ~deb_state;
   assign advance    = pending | (auto_en & (frame_cnt == LAST_FRAME));

   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         vsync_d   <= 1'b0;
         key_s1    <= 1'b1;
         key_s2    <= 1'b1;
         deb_state <= 1'b1;
         deb_d     <= 1'b1;
         deb_cnt   <= 20'd0;
      end else begin
         vsync_d <= vsync_in;
         key_s1  <= key_n;
         key_s2  <= key_s1;
         deb_d   <= deb_state;
         if (key_s2 != deb_state) begin
            if (deb_cnt == DEB_LAST) begin
               deb_state <= key_s2;
               deb_cnt   <= 20'd0;
            end else begin
               deb_cnt <= deb_cnt + 20'd1;
            end
         end else begin
            deb_cnt <= 20'd0;
         end
      end
   end

   always_ff @(posedge pixel_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state       <= S_WAIT_SYNC;
         pattern_sel <= 3'd0;
         pattern_chg <= 1'b0;
         locked      <= 1'b0;
         pending     <= 1'b0;
         frame_cnt   <= 8'd0;
      end else begin
         pattern_chg <= 1'b0;
         case (state)
            S_WAIT_SYNC: begin
               pending <= 1'b0;
               if (frame_tick) begin
                  state  <= S_RUN;
                  locked <= 1'b1;
               end
            end
            S_RUN: begin
               if (freeze) begin
                  state   <= S_FREEZE;
                  pending <= 1'b0;
               end else if (frame_tick) begin
                  if (advance) begin
                     pattern_sel <= (pattern_sel == LAST_PAT) ? 3'd0 : pattern_sel + 3'd1;
                     pattern_chg <= 1'b1;
                     frame_cnt   <= 8'd0;
                     // a press landing on the advancing tick carries over to the next frame
                     pending     <= press;
                  end else begin
                     if (auto_en) frame_cnt <= frame_cnt + 8'd1;
                     pending <= pending | press;
                  end
               end else if (press) begin
                  pending <= 1'b1;
               end
            end
            S_FREEZE: begin
               pending <= 1'b0;
               if (!freeze) state <= S_RUN;
            end
            default: begin
               state   <= S_WAIT_SYNC;
               pending <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_video_pattern_sched.sv
// Bench for video_pattern_sched: vector table of frame/key events plus corner-case sequences.
module tb_video_pattern_sched;

   logic       pixel_clk;
   logic       sys_rst;
   logic       vsync_in;
   logic       key_n;
   logic       auto_en;
   logic       freeze;
   logic [2:0] pattern_sel;
   logic       pattern_chg;
   logic       locked;

   int errors = 0;
   int checks = 0;
   int chg_seen = 0;

   typedef struct {
      logic       rst;
      logic       auto_en;
      logic       freeze;
      int         presses;
      logic       vsync;
      logic [2:0] sel;
      logic       chg;
      logic       lock;
   } vec_t;

   vec_t       tbl[$];
   logic [4:0] sb_q[$];

   video_pattern_sched #(
      .NUM_PATTERNS      (8),
      .FRAMES_PER_PATTERN(3),
      .DEBOUNCE_CYCLES   (20'd4)
   ) dut (
      .pixel_clk  (pixel_clk),
      .sys_rst    (sys_rst),
      .vsync_in   (vsync_in),
      .key_n      (key_n),
      .auto_en    (auto_en),
      .freeze     (freeze),
      .pattern_sel(pattern_sel),
      .pattern_chg(pattern_chg),
      .locked     (locked)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   always @(negedge pixel_clk) if (pattern_chg === 1'b1) chg_seen++;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge pixel_clk);
      #1;
   endtask

   task automatic pop_check(input string name);
      logic [4:0] exp;
      logic [4:0] act;
      checks++;
      act = {locked, pattern_chg, pattern_sel};
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty, got lock=%0b chg=%0b sel=%0d", name, act[4], act[3], act[2:0]);
      end else begin
         exp = sb_q.pop_front();
         if (act !== exp) begin
            errors++;
            $display("FAIL %s: got lock=%0b chg=%0b sel=%0d, want lock=%0b chg=%0b sel=%0d",
                     name, act[4], act[3], act[2:0], exp[4], exp[3], exp[2:0]);
         end
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic do_reset(input string name);
      vsync_in = 1'b0;
      key_n    = 1'b1;
      sys_rst  = 1'b1;
      step(2);
      sb_q.push_back(5'b0);
      pop_check(name);
      sys_rst = 1'b0;
      step(1);
   endtask

   // bouncing press: short glitches at both edges, then a clean release
   task automatic press_key();
      key_n = 1'b0; step(1);
      key_n = 1'b1; step(1);
      key_n = 1'b0; step(2);
      key_n = 1'b1; step(1);
      key_n = 1'b0; step(10);
      key_n = 1'b1; step(1);
      key_n = 1'b0; step(2);
      key_n = 1'b1; step(12);
   endtask

   // vsync held high two cycles: only the first edge may act
   task automatic vsync_pulse(input string name, input logic [2:0] sel, input logic chg, input logic lock);
      sb_q.push_back({lock, chg, sel});
      vsync_in = 1'b1;
      step(1);
      pop_check(name);
      sb_q.push_back({lock, 1'b0, sel});
      step(1);
      pop_check({name, "_hold"});
      vsync_in = 1'b0;
      step(2);
   endtask

   task automatic idle_check(input string name, input logic [2:0] sel, input logic lock);
      sb_q.push_back({lock, 1'b0, sel});
      step(2);
      pop_check(name);
   endtask

   task automatic add(input logic rst, input logic ae, input logic fz, input int pr, input logic vs,
                      input logic [2:0] sel, input logic chg, input logic lock);
      vec_t v;
      v.rst = rst; v.auto_en = ae; v.freeze = fz; v.presses = pr; v.vsync = vs;
      v.sel = sel; v.chg = chg; v.lock = lock;
      tbl.push_back(v);
   endtask

   initial begin
      vec_t r;
      int   c0;
      logic [2:0] exp_sel;

      sys_rst = 1'b1; vsync_in = 1'b0; key_n = 1'b1; auto_en = 1'b0; freeze = 1'b0;

      //  rst ae fz pr vs sel chg lock
      add(1, 1, 0, 0, 0, 0, 0, 0);          // auto cycling, 7 frames
      add(0, 1, 0, 0, 1, 0, 0, 1);
      add(0, 1, 0, 0, 1, 0, 0, 1);
      add(0, 1, 0, 0, 1, 0, 0, 1);
      add(0, 1, 0, 0, 1, 1, 1, 1);
      add(0, 1, 0, 0, 1, 1, 0, 1);
      add(0, 1, 0, 0, 1, 1, 0, 1);
      add(0, 1, 0, 0, 1, 2, 1, 1);
      add(1, 0, 0, 0, 0, 0, 0, 0);          // manual stepping
      add(0, 0, 0, 0, 1, 0, 0, 1);
      add(0, 0, 0, 2, 1, 1, 1, 1);
      add(0, 0, 0, 0, 1, 1, 0, 1);
      for (int p = 2; p < 8; p++) add(0, 0, 0, 1, 1, 3'(p), 1, 1);
      add(0, 0, 0, 1, 1, 0, 1, 1);          // wrap 7 -> 0
      add(0, 1, 0, 0, 1, 0, 0, 1);          // count 1
      add(0, 1, 0, 0, 1, 0, 0, 1);          // count 2
      add(0, 1, 0, 1, 1, 1, 1, 1);          // expiry + pending: one step
      add(0, 1, 0, 0, 1, 1, 0, 1);
      add(0, 1, 0, 0, 1, 1, 0, 1);
      add(0, 1, 0, 0, 1, 2, 1, 1);
      add(1, 0, 0, 0, 0, 0, 0, 0);          // press before lock is dropped
      add(0, 0, 0, 1, 0, 0, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0, 0, 1);
      add(1, 1, 0, 0, 0, 0, 0, 0);          // freeze holds count and drops presses
      add(0, 1, 0, 0, 1, 0, 0, 1);
      add(0, 1, 0, 0, 1, 0, 0, 1);
      add(0, 1, 1, 0, 0, 0, 0, 1);
      add(0, 1, 1, 1, 1, 0, 0, 1);
      for (int p = 0; p < 4; p++) add(0, 1, 1, 0, 1, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 1, 0, 0, 1, 0, 0, 1);
      add(0, 1, 0, 0, 1, 1, 1, 1);
      add(0, 1, 0, 0, 1, 1, 0, 1);          // auto_en drop holds count
      add(0, 0, 0, 0, 1, 1, 0, 1);
      add(0, 0, 0, 0, 1, 1, 0, 1);
      add(0, 1, 0, 0, 1, 1, 0, 1);
      add(0, 1, 0, 0, 1, 2, 1, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         r = tbl[i];
         auto_en = r.auto_en;
         freeze  = r.freeze;
         if (r.rst) begin
            do_reset($sformatf("row%0d_reset", i));
         end else begin
            for (int k = 0; k < r.presses; k++) press_key();
            if (r.vsync) vsync_pulse($sformatf("row%0d", i), r.sel, r.chg, r.lock);
            else         idle_check($sformatf("row%0d", i), r.sel, r.lock);
         end
      end

      // freeze rising on the same cycle as a tick wins; count stays at 2
      auto_en = 1'b1; freeze = 1'b0;
      do_reset("seqa_reset");
      vsync_pulse("seqa_lock", 0, 0, 1);
      vsync_pulse("seqa_cnt1", 0, 0, 1);
      vsync_pulse("seqa_cnt2", 0, 0, 1);
      freeze = 1'b1; vsync_in = 1'b1;
      sb_q.push_back({1'b1, 1'b0, 3'd0});
      step(1);
      pop_check("seqa_freeze_tick");
      vsync_in = 1'b0;
      step(2);
      freeze = 1'b0;
      step(2);
      vsync_pulse("seqa_resume", 1, 1, 1);

      // press swept across a tick: exactly one step, never lost
      auto_en = 1'b0;
      exp_sel = 3'd1;
      for (int k = 3; k <= 9; k++) begin
         c0 = chg_seen;
         key_n = 1'b0;
         step(k);
         vsync_in = 1'b1; step(1); vsync_in = 1'b0;
         step(11 - k);
         key_n = 1'b1;
         step(10);
         vsync_in = 1'b1; step(1); vsync_in = 1'b0;
         step(2);
         exp_sel = (exp_sel == 3'd7) ? 3'd0 : exp_sel + 3'd1;
         sb_q.push_back({1'b1, 1'b0, exp_sel});
         pop_check($sformatf("seqb_off%0d_sel", k));
         check_int($sformatf("seqb_off%0d_chg_pulses", k), chg_seen - c0, 1);
      end

      // async reset mid-run clears outputs without waiting for an edge
      press_key();
      exp_sel = (exp_sel == 3'd7) ? 3'd0 : exp_sel + 3'd1;
      vsync_pulse("seqc_step", exp_sel, 1, 1);
      #2;
      sys_rst = 1'b1;
      #1;
      sb_q.push_back(5'b0);
      pop_check("seqc_async_reset");
      step(1);
      sb_q.push_back(5'b0);
      pop_check("seqc_reset_held");
      sys_rst = 1'b0;
      step(1);
      vsync_pulse("seqc_relock", 0, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/video_pattern_sched.md
Name: video_pattern_sched

Overview:
- Selects which test pattern the video pixel-data generator shows on the HDMI output.
- Supports automatic cycling every N frames and manual stepping with a push-button.
- Pattern changes happen only at frame boundaries (rising edge of vsync), so a frame is never torn.
- Sits beside the timing generator and drives the pattern-select input of the pixel-data generator, all in the pixel_clk domain.

Parameters:
- NUM_PATTERNS, 8: number of selectable patterns; legal range 2..8.
- FRAMES_PER_PATTERN, 60: frames each pattern is shown in auto mode; legal range 1..255.
- DEBOUNCE_CYCLES, 20'd1000000: consecutive stable cycles needed to accept a key level; legal range 2..2^20-1.

Ports:
- pixel_clk  in  1  pixel clock; all logic is on the rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- vsync_in  in  1  vertical sync from the timing generator, active high, same clock domain.
- key_n  in  1  raw push-button, active low, asynchronous, bouncing.
- auto_en  in  1  1 = auto-cycle enabled.
- freeze  in  1  1 = hold the current pattern; ignores auto expiry and key presses.
- pattern_sel  out  3  index of the active pattern.
- pattern_chg  out  1  one-cycle pulse, asserted in the same cycle pattern_sel takes a new value.
- locked  out  1  1 once the first frame boundary has been seen after reset.

Behaviour:
- Reset (async assert, sync use after release):
  - pattern_sel=0, pattern_chg=0, locked=0.
  - Frame counter=0, pending=0, state=S_WAIT_SYNC.
  - Both key sync flops=1, debounced key state=1, debounce counter=0, vsync_d=0.
  - Reset asserted mid-operation abandons all progress immediately.
- Frame tick: frame_tick = vsync_in & ~vsync_d, where vsync_d is vsync_in registered. If vsync_in is sampled high first at edge N, the update happens at edge N, and the new pattern_sel and pattern_chg=1 are visible after edge N.
- Key path:
  - 2-flop synchronizer on key_n.
  - The debounce counter increments while the synced value differs from the debounced state, and clears otherwise.
  - When the count reaches DEBOUNCE_CYCLES-1 and the synced value still differs, the debounced state takes the synced value and the counter clears.
  - A 1→0 transition of the debounced state is a press; it sets pending=1 on the next edge.
  - A press while pending=1 has no extra effect: there is never more than one step per frame.
- FSM:
  - S_WAIT_SYNC: pattern_sel held at 0, presses discarded (pending stays 0). On frame_tick → S_RUN with locked=1; this first tick does not advance the pattern or count.
  - S_RUN:
    - freeze=1 → S_FREEZE immediately; pending is cleared and the frame counter is held.
    - Otherwise, on each frame_tick, advance if pending=1, or if auto_en=1 and frame counter = FRAMES_PER_PATTERN-1.
    - Advance means: pattern_sel ← (pattern_sel = NUM_PATTERNS-1) ? 0 : pattern_sel+1; pattern_chg=1; frame counter ← 0; pending ← 0.
    - No advance on a tick: the frame counter increments if auto_en=1, and is held if auto_en=0.
  - S_FREEZE: pattern_sel and frame counter held, presses discarded. freeze=0 → S_RUN; counting resumes from the held value.
- Simultaneous events:
  - Auto expiry and pending on the same tick → exactly one advance.
  - A press event in the same cycle as an advancing tick is not lost: pending=1 afterwards, applied at the next tick.
  - freeze rising in the same cycle as a tick → freeze wins, no advance.
- auto_en falling mid-count holds the counter; rising resumes it.
- pattern_chg is 0 in every cycle with no advance.
- The frame counter is 8 bits and never exceeds FRAMES_PER_PATTERN-1.

Test Plan (DEBOUNCE_CYCLES=4, FRAMES_PER_PATTERN=3, NUM_PATTERNS=8):
- Reset, auto_en=1, 7 vsync pulses → locked=1 after pulse 1; pattern_sel goes 0→1 at pulse 4 and 1→2 at pulse 7, pattern_chg exactly 2 single-cycle pulses, each aligned with the change.
- auto_en=0, key_n low for 10 cycles with bounces of 1–2 cycles at the edges, then 1 vsync → exactly one step 0→1 at the vsync; a second press before the vsync does not make it 0→2.
- Start at pattern_sel=7, one press + vsync → wraps to 0, pattern_chg=1.
- auto_en=1 with counter at 2, press pending, vsync → single advance, counter=0; next advance needs 3 more vsyncs.
- Press before the first vsync after reset, then 2 vsyncs with auto_en=0 → pattern_sel stays 0 (press discarded in S_WAIT_SYNC).
- freeze=1 across 5 vsyncs with auto_en=1 and a press → no change; freeze=0 → auto advance resumes from the held count; assert sys_rst mid-run → all outputs 0 immediately.
